fft64_sched: RTL and testbench

- Time-shares one fully parallel 64-point FFT core (5-cycle pipeline, i_valid/o_valid, no stall input) between NREQ frame sources, e.g. X/Y polarisation front-ends.
- Round-robin arbitration among requesters, gated by per-requester downstream credits.
- Drives the FFT input bus and tags every issued frame with its requester ID.
- Steers each FFT output frame back to its owner and flags tag/valid misalignment.

---
 rtl/fe_fft_pkg.sv | 22 ++
 rtl/fe_rr_arb.sv | 29 ++
 rtl/fft64_sched.sv | 134 +++++++++++++
 tb/tb_fft64_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_fft_pkg.sv
// Shared constants and types for the front-end FFT scheduling blocks.
package fe_fft_pkg;

  localparam int FFT64_NPTS = 64;
  localparam int FFT64_LAT  = 5;

  // Tag id field is sized for the largest supported requester count (8).
  localparam int FFT64_IDW  = 3;

  localparam int FE_NBW_IN  = 9;
  localparam int FE_NBW_OUT = 13;

  typedef struct packed {
    logic                 vld;
    logic [FFT64_IDW-1:0] id;
  } fft_tag_t;

  // Frame layout: [sample k][0=I, 1=Q][bit].
  typedef logic [FFT64_NPTS-1:0][1:0][FE_NBW_IN-1:0]  fft_in_frame_t;
  typedef logic [FFT64_NPTS-1:0][1:0][FE_NBW_OUT-1:0] fft_out_frame_t;

endpackage

// File: rtl/fe_rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 with wrap.
module fe_rr_arb #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/fft64_sched.sv
// Time-shares one 64-point FFT core between NREQ credit-gated frame sources,
// tagging each issued frame and steering results back to their owner.
module fft64_sched
  import fe_fft_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int NBW_IN  = 9,
  parameter int NBW_OUT = 13,
  parameter int LAT     = FFT64_LAT,
  parameter int CRED    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_async_n,
  input  logic                                  i_en,
  input  logic [NREQ-1:0]                       i_req_valid,
  input  logic [NREQ*FFT64_NPTS*2*NBW_IN-1:0]   i_req_data,
  output logic [NREQ-1:0]                       o_req_ready,
  output logic                                  o_fft_valid,
  output logic [FFT64_NPTS*2*NBW_IN-1:0]        o_fft_data,
  input  logic                                  i_fft_valid,
  input  logic [FFT64_NPTS*2*NBW_OUT-1:0]       i_fft_data,
  output logic [NREQ-1:0]                       o_valid,
  output logic [FFT64_NPTS*2*NBW_OUT-1:0]       o_data,
  input  logic [NREQ-1:0]                       i_cred_ret,
  output logic                                  o_busy,
  output logic                                  o_err
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CW   = $clog2(CRED + 1);
  localparam int FIN  = FFT64_NPTS * 2 * NBW_IN;
  localparam int FOUT = FFT64_NPTS * 2 * NBW_OUT;

  logic [CW-1:0]   cred_q [NREQ];
  logic [CW-1:0]   cred_d [NREQ];
  logic [IDW-1:0]  ptr_q;
  logic            fft_valid_q;
  logic [FIN-1:0]  fft_data_q;
  logic [IDW-1:0]  fft_id_q;
  fft_tag_t        tag_q [LAT];
  fft_tag_t        tag_in;
  logic [NREQ-1:0] valid_q, valid_d;
  logic [FOUT-1:0] data_q;
  logic            err_q, err_d;

  logic [NREQ-1:0] elig, gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [FIN-1:0]  sel_data;
  logic            load_out;
  logic            tag_busy;

  // Handshake: requester r's frame is accepted in the cycle where
  // i_req_valid[r] & o_req_ready[r]; ready never waits on valid being held.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      elig[r] = i_en & i_req_valid[r] & (cred_q[r] != '0);
    end
  end

  fe_rr_arb #(.N(NREQ)) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign sel_data = i_req_data[int'(gnt_idx)*FIN +: FIN];

  always_comb begin
    err_d      = err_q;
    valid_d    = '0;
    load_out   = 1'b0;
    tag_busy   = 1'b0;
    tag_in.vld = fft_valid_q;
    tag_in.id  = FFT64_IDW'(fft_id_q);
    for (int s = 0; s < LAT; s++) begin
      tag_busy |= tag_q[s].vld;
    end
    // A result without a matching tag (or a tag without a result) is never routed.
    if (i_fft_valid != tag_q[LAT-1].vld) begin
      err_d = 1'b1;
    end else if (tag_q[LAT-1].vld) begin
      load_out = 1'b1;
      valid_d  = NREQ'(1) << tag_q[LAT-1].id;
    end
    for (int r = 0; r < NREQ; r++) begin
      cred_d[r] = cred_q[r];
      if (gnt[r] && !i_cred_ret[r]) begin
        cred_d[r] = cred_q[r] - CW'(1);
      end else if (!gnt[r] && i_cred_ret[r]) begin
        if (cred_q[r] == CW'(CRED)) err_d = 1'b1;
        else                        cred_d[r] = cred_q[r] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      ptr_q       <= IDW'(NREQ - 1);
      fft_valid_q <= 1'b0;
      fft_data_q  <= '0;
      fft_id_q    <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      for (int r = 0; r < NREQ; r++) cred_q[r] <= CW'(CRED);
      for (int s = 0; s < LAT; s++)  tag_q[s]  <= '0;
    end else begin
      fft_valid_q <= gnt_any;
      if (gnt_any) begin
        ptr_q      <= gnt_idx;
        fft_data_q <= sel_data;
        fft_id_q   <= gnt_idx;
      end
      tag_q[0] <= tag_in;
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
      valid_q <= valid_d;
      if (load_out) data_q <= i_fft_data;
      err_q <= err_d;
      for (int r = 0; r < NREQ; r++) cred_q[r] <= cred_d[r];
    end
  end

  assign o_req_ready = gnt;
  assign o_fft_valid = fft_valid_q;
  assign o_fft_data  = fft_data_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_err       = err_q;
  assign o_busy      = fft_valid_q | tag_busy | (|valid_q);

endmodule

// File: tb/tb_fft64_sched.sv
// Bench for fft64_sched: FFT stub with fixed delay, scoreboard on routed results.
module tb_fft64_sched;

  localparam int NREQ    = 2;
  localparam int NBW_IN  = 9;
  localparam int NBW_OUT = 13;
  localparam int LAT     = 5;
  localparam int CRED    = 4;
  localparam int FIN     = 64 * 2 * NBW_IN;
  localparam int FOUT    = 64 * 2 * NBW_OUT;
  localparam int SBW     = 1 + FOUT;

  logic                 clk = 1'b0;
  logic                 rst_async_n;
  logic                 i_en;
  logic [NREQ-1:0]      i_req_valid;
  logic [FIN-1:0]       req_frame [NREQ];
  logic [NREQ*FIN-1:0]  i_req_data;
  logic [NREQ-1:0]      o_req_ready;
  logic                 o_fft_valid;
  logic [FIN-1:0]       o_fft_data;
  logic                 i_fft_valid;
  logic [FOUT-1:0]      i_fft_data;
  logic [NREQ-1:0]      o_valid;
  logic [FOUT-1:0]      o_data;
  logic [NREQ-1:0]      i_cred_ret;
  logic                 o_busy;
  logic                 o_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic mon_en = 1'b1;
  logic drop_arm = 1'b0;
  logic [SBW-1:0] exp_q[$];

  assign i_req_data = {req_frame[1], req_frame[0]};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft64_sched #(
    .NREQ(NREQ), .NBW_IN(NBW_IN), .NBW_OUT(NBW_OUT), .LAT(LAT), .CRED(CRED)
  ) dut (
    .clk(clk), .rst_async_n(rst_async_n), .i_en(i_en),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_fft_valid(o_fft_valid), .o_fft_data(o_fft_data),
    .i_fft_valid(i_fft_valid), .i_fft_data(i_fft_data),
    .o_valid(o_valid), .o_data(o_data), .i_cred_ret(i_cred_ret),
    .o_busy(o_busy), .o_err(o_err)
  );

  // FFT stand-in: sign-extends every sample, LAT cycles from i_valid to o_valid.
  function automatic logic [FOUT-1:0] fft_model(input logic [FIN-1:0] f);
    logic [FOUT-1:0] o;
    o = '0;
    for (int k = 0; k < 128; k++) begin
      o[k*NBW_OUT +: NBW_OUT] = {{(NBW_OUT-NBW_IN){f[k*NBW_IN+NBW_IN-1]}}, f[k*NBW_IN +: NBW_IN]};
    end
    return o;
  endfunction

  logic            sv [LAT];
  logic [FOUT-1:0] sd [LAT];
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      for (int i = 0; i < LAT; i++) begin
        sv[i] <= 1'b0;
        sd[i] <= '0;
      end
    end else begin
      sv[0] <= o_fft_valid & ~drop_arm;
      sd[0] <= fft_model(o_fft_data);
      for (int i = 1; i < LAT; i++) begin
        sv[i] <= sv[i-1];
        sd[i] <= sd[i-1];
      end
    end
  end
  assign i_fft_valid = sv[LAT-1];
  assign i_fft_data  = sd[LAT-1];

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [SBW-1:0] e;
    if (rst_async_n && mon_en) begin
      if (|(o_req_ready & i_req_valid))
        exp_q.push_back({o_req_ready[1], fft_model(o_req_ready[1] ? req_frame[1] : req_frame[0])});
      if (o_valid != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: o_valid=%b, expected no output", o_valid);
        end else begin
          e = exp_q.pop_front();
          if (o_valid !== (e[SBW-1] ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL sb_route: o_valid=%b, expected owner %0d", o_valid, e[SBW-1]);
          end
          checks++;
          if (o_data !== e[FOUT-1:0]) begin
            errors++;
            $display("FAIL sb_data: o_data[63:0]=%h expected %h", o_data[63:0], e[63:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FIN-1:0] rand_frame();
    logic [FIN-1:0] f;
    for (int i = 0; i < FIN/32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic ret_credits(input logic [1:0] m, input int n);
    repeat (n) begin
      tick();
      i_cred_ret = m;
    end
    tick();
    i_cred_ret = '0;
  endtask

  task automatic drain(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_async_n = 1'b0;
    i_en = 1'b0;
    i_req_valid = 2'b11;
    i_cred_ret = '0;
    req_frame[0] = rand_frame();
    req_frame[1] = rand_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_fft_valid !== 1'b0) begin errors++; $display("FAIL rst_fft_valid: got %b want 0", o_fft_valid); end
    checks++; if (o_valid !== 2'b00)    begin errors++; $display("FAIL rst_valid: got %b want 00", o_valid); end
    checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    checks++; if (o_err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b want 0", o_err); end
    checks++; if (o_fft_data !== '0)    begin errors++; $display("FAIL rst_fft_data: got %h want 0", o_fft_data[63:0]); end
    checks++; if (o_data !== '0)        begin errors++; $display("FAIL rst_data: got %h want 0", o_data[63:0]); end
    tick();
    rst_async_n = 1'b1;
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL en_low_ready: got %b want 00", o_req_ready); end
    tick();
    i_req_valid = '0;
  endtask

  task automatic test_single();
    int acc_cyc;
    logic found, ok;
    for (int k = 0; k < 64; k++) begin
      req_frame[0][(2*k)*NBW_IN +: NBW_IN]   = NBW_IN'(k);
      req_frame[0][(2*k+1)*NBW_IN +: NBW_IN] = NBW_IN'(-k);
    end
    tick();
    i_en = 1'b1;
    i_req_valid = 2'b01;
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", o_req_ready); end
    acc_cyc = cyc;
    tick();
    i_req_valid = '0;
    @(negedge clk);
    checks++; if (o_fft_valid !== 1'b1) begin errors++; $display("FAIL single_fft_valid: got %b want 1", o_fft_valid); end
    checks++; if (o_fft_data !== req_frame[0]) begin errors++; $display("FAIL single_fft_data: got %h want %h", o_fft_data[63:0], req_frame[0][63:0]); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (o_valid != '0) begin
        found = 1'b1;
        checks++;
        if (o_valid !== 2'b01 || cyc - acc_cyc != 7) begin
          errors++;
          $display("FAIL single_latency: o_valid=%b after %0d cycles, want 01 after 7", o_valid, cyc - acc_cyc);
        end
      end
    end
    if (!found) begin checks++; errors++; $display("FAIL single_timeout: no o_valid within 20 cycles, want one"); end
    ret_credits(2'b01, 1);
    drain(ok);
    checks++; if (!ok || o_err !== 1'b0) begin errors++; $display("FAIL single_done: idle=%b err=%b want 1/0", ok, o_err); end
  endtask

  task automatic test_fairness();
    logic exp_g, ok;
    exp_g = 1'b1;  // requester 0 won last, so 1 is next in line
    tick();
    i_req_valid = 2'b11;
    req_frame[0] = rand_frame();
    req_frame[1] = rand_frame();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (o_req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fair_grant%0d: got %b want %b", i, o_req_ready, exp_g ? 2'b10 : 2'b01);
      end
      exp_g = ~exp_g;
      tick();
      req_frame[0] = rand_frame();
      req_frame[1] = rand_frame();
    end
    i_req_valid = '0;
    drain(ok);
    checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL fair_drain: idle=%b pending=%0d want 1/0", ok, exp_q.size()); end
    ret_credits(2'b11, 4);
  endtask

  task automatic test_credit_stall();
    int cnt;
    logic ok;
    tick();
    i_req_valid = 2'b01;
    req_frame[0] = rand_frame();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_req_ready[0]) cnt++;
      tick();
      req_frame[0] = rand_frame();
    end
    checks++; if (cnt != 4) begin errors++; $display("FAIL stall_accepts: got %0d want 4", cnt); end
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready: got %b want 00", o_req_ready); end
    tick();
    i_cred_ret = 2'b01;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_req_ready[0]) cnt++;
      tick();
      i_cred_ret = '0;
      req_frame[0] = rand_frame();
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL stall_one_more: got %0d want 1", cnt); end
    i_req_valid = '0;
    drain(ok);
    ret_credits(2'b01, 4);
    checks++; if (!ok || o_err !== 1'b0) begin errors++; $display("FAIL stall_done: idle=%b err=%b want 1/0", ok, o_err); end
  endtask

  task automatic test_accept_return();
    logic ok;
    tick();
    i_req_valid = 2'b10;
    req_frame[1] = rand_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (o_req_ready !== 2'b10) begin errors++; $display("FAIL ar_pre%0d: got %b want 10", i, o_req_ready); end
      tick();
      req_frame[1] = rand_frame();
    end
    i_cred_ret = 2'b10;
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b10) begin errors++; $display("FAIL ar_same_cycle: got %b want 10", o_req_ready); end
    tick();
    i_cred_ret = '0;
    req_frame[1] = rand_frame();
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b10) begin errors++; $display("FAIL ar_cred_kept: got %b want 10", o_req_ready); end
    tick();
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL ar_cred_empty: got %b want 00", o_req_ready); end
    tick();
    i_req_valid = '0;
    drain(ok);
    ret_credits(2'b10, 4);
    checks++; if (!ok || o_err !== 1'b0) begin errors++; $display("FAIL ar_done: idle=%b err=%b want 1/0", ok, o_err); end
  endtask

  task automatic test_en_drain();
    int nout, last_v, idle_c;
    logic bad_ready, done, ok;
    tick();
    i_req_valid = 2'b01;
    req_frame[0] = rand_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL drain_acc%0d: got %b want 01", i, o_req_ready); end
      tick();
      req_frame[0] = rand_frame();
    end
    i_en = 1'b0;
    nout = 0; last_v = 0; idle_c = -1; bad_ready = 1'b0; done = 1'b0;
    for (int i = 0; i < 25 && !done; i++) begin
      @(negedge clk);
      if (o_req_ready != '0) bad_ready = 1'b1;
      if (o_valid != '0) begin
        nout++;
        last_v = cyc;
      end else if (nout == 3 && !o_busy) begin
        idle_c = cyc;
        done = 1'b1;
      end
    end
    checks++; if (bad_ready) begin errors++; $display("FAIL drain_no_grant: ready seen with i_en=0, want none"); end
    checks++; if (nout != 3) begin errors++; $display("FAIL drain_outputs: got %0d want 3", nout); end
    checks++; if (idle_c != last_v + 1) begin errors++; $display("FAIL drain_busy_fall: idle at %0d, want %0d", idle_c, last_v + 1); end
    tick();
    i_en = 1'b1;
    @(negedge clk);
    checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL drain_resume: got %b want 01", o_req_ready); end
    tick();
    i_req_valid = '0;
    drain(ok);
    ret_credits(2'b01, 4);
  endtask

  task automatic test_errors();
    logic seen, ok;
    int cnt;
    // Extra return on a full counter.
    ret_credits(2'b10, 1);
    @(negedge clk);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_cred_overflow: got %b want 1", o_err); end
    repeat (5) tick();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", o_err); end
    rst_async_n = 1'b0;
    #1;
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", o_err); end
    tick();
    rst_async_n = 1'b1;
    // FFT drops one result.
    mon_en = 1'b0;
    drop_arm = 1'b1;
    tick();
    i_req_valid = 2'b01;
    req_frame[0] = rand_frame();
    tick();
    i_req_valid = '0;
    tick();
    drop_arm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_valid != '0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL err_drop_valid: o_valid asserted, want none"); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_drop_flag: got %b want 1", o_err); end
    exp_q.delete();
    mon_en = 1'b1;
    // Reset while frames are in flight.
    tick();
    i_req_valid = 2'b01;
    req_frame[0] = rand_frame();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tick();
      req_frame[0] = rand_frame();
    end
    i_req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      @(negedge clk);
      if (o_valid != '0) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_timeout: no output before reset, want one"); end
    #2;
    rst_async_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (o_valid !== 2'b00 || o_fft_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: valid=%b fft_valid=%b want 00/0", o_valid, o_fft_valid); end
    checks++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL mid_rst_busy_err: busy=%b err=%b want 0/0", o_busy, o_err); end
    checks++; if (o_data !== '0 || o_fft_data !== '0) begin errors++; $display("FAIL mid_rst_data: data=%h fft_data=%h want 0", o_data[63:0], o_fft_data[63:0]); end
    tick();
    rst_async_n = 1'b1;
    tick();
    i_req_valid = 2'b01;
    req_frame[0] = rand_frame();
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (o_req_ready[0]) cnt++;
      tick();
      req_frame[0] = rand_frame();
    end
    i_req_valid = '0;
    checks++; if (cnt != 4) begin errors++; $display("FAIL mid_cred_restored: got %0d accepts want 4", cnt); end
    drain(ok);
    checks++; if (!ok || o_err !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL mid_done: idle=%b err=%b pending=%0d want 1/0/0", ok, o_err, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_credit_stall();
    test_accept_return();
    test_en_drain();
    test_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
